bam_cfg_ctrl: RTL and testbench

Configuration controller for the one-channel BAM generator. It owns a 4-register bus-accessible shadow bank (CONFIG, DCYCLE, STEP, STATUS). It drives the generator's on, prescale and duty inputs, and commits changes only at BAM frame boundaries so no partial frame ever runs with mixed settings. It also sequences an optional per-frame duty-cycle ramp (fade) toward a target value, with a completion pulse.

---
 rtl/bam_cfg_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_bam_cfg_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bam_cfg_ctrl.sv
// Configuration controller for the one-channel BAM generator: bus shadow bank,
// frame-boundary commit of on/prescale/duty, and an optional per-frame duty ramp.
module bam_cfg_ctrl (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic       i_rd_en,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_frame_end,
  output logic [7:0] o_rdata,
  output logic       o_ack,
  output logic       o_on,
  output logic [2:0] o_presc_mode,
  output logic [7:0] o_duty_cycle,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_RAMP = 2'd2;

  localparam logic [1:0] ADDR_CONFIG = 2'd0;
  localparam logic [1:0] ADDR_DCYCLE = 2'd1;
  localparam logic [1:0] ADDR_STEP   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [1:0] state_q, state_d;
  logic       cfg_on_q, cfg_on_d;
  logic [2:0] cfg_presc_q, cfg_presc_d;
  logic       cfg_ramp_q, cfg_ramp_d;
  logic [7:0] target_q, target_d;
  logic [7:0] step_q, step_d;
  logic       pending_q, pending_d;
  logic       sticky_q, sticky_d;
  logic       on_q, on_d;
  logic [2:0] presc_q, presc_d;
  logic [7:0] duty_q, duty_d;
  logic       done_q, done_d;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;

  logic       wr_shadow;
  logic       safety_off;
  logic       rd_only;
  logic       busy;
  logic       pend_commit;
  logic [7:0] start_duty;
  logic       ramp_go;
  logic [7:0] gap;
  logic [7:0] ramp_adj;
  logic [7:0] ramp_next;

  assign wr_shadow   = i_wr_en && (i_addr != ADDR_STATUS);
  assign safety_off  = i_wr_en && (i_addr == ADDR_CONFIG) && !i_wdata[0] && on_q;
  assign rd_only     = i_rd_en && !i_wr_en;
  assign busy        = (state_q != ST_IDLE);
  // With the generator off no frame_end will arrive, so commit as soon as the bus goes quiet.
  assign pend_commit = i_frame_end || (!on_q && !wr_shadow);
  assign start_duty  = (cfg_on_q && !on_q) ? 8'd0 : duty_q;
  assign ramp_go     = cfg_on_q && cfg_ramp_q && (step_q != 8'd0) && (start_duty != target_q);

  // The step is clipped to the remaining distance, so the result never passes the target.
  always_comb begin
    gap       = (target_q > duty_q) ? (target_q - duty_q) : (duty_q - target_q);
    ramp_adj  = (step_q < gap) ? step_q : gap;
    ramp_next = target_q;
    if (cfg_ramp_q && (step_q != 8'd0)) begin
      ramp_next = (target_q > duty_q) ? (duty_q + ramp_adj) : (duty_q - ramp_adj);
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_on_d    = cfg_on_q;
    cfg_presc_d = cfg_presc_q;
    cfg_ramp_d  = cfg_ramp_q;
    target_d    = target_q;
    step_d      = step_q;
    pending_d   = pending_q;
    sticky_d    = sticky_q;
    on_d        = on_q;
    presc_d     = presc_q;
    duty_d      = duty_q;
    done_d      = 1'b0;
    ack_d       = i_wr_en | i_rd_en;
    rdata_d     = 8'd0;

    if (rd_only) begin
      case (i_addr)
        ADDR_CONFIG: rdata_d = {3'b000, cfg_ramp_q, cfg_presc_q, cfg_on_q};
        ADDR_DCYCLE: rdata_d = target_q;
        ADDR_STEP:   rdata_d = step_q;
        default:     rdata_d = {5'b00000, sticky_q, pending_q, busy};
      endcase
      if (i_addr == ADDR_STATUS) sticky_d = 1'b0;
    end

    if (safety_off) begin
      on_d      = 1'b0;
      presc_d   = i_wdata[3:1];
      duty_d    = 8'd0;
      pending_d = 1'b0;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_shadow) begin
            pending_d = 1'b1;
            state_d   = ST_PEND;
          end
        end
        ST_PEND: begin
          if (pend_commit) begin
            on_d      = cfg_on_q;
            presc_d   = cfg_presc_q;
            pending_d = wr_shadow;
            if (ramp_go) begin
              duty_d  = start_duty;
              state_d = ST_RAMP;
            end else begin
              duty_d  = target_q;
              state_d = wr_shadow ? ST_PEND : ST_IDLE;
            end
          end
        end
        ST_RAMP: begin
          if (wr_shadow) pending_d = 1'b1;
          if (i_frame_end) begin
            on_d      = cfg_on_q;
            presc_d   = cfg_presc_q;
            pending_d = wr_shadow;
            duty_d    = ramp_next;
            if (ramp_next == target_q) begin
              done_d   = 1'b1;
              sticky_d = 1'b1;
              state_d  = wr_shadow ? ST_PEND : ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (i_wr_en) begin
      case (i_addr)
        ADDR_CONFIG: begin
          cfg_on_d    = i_wdata[0];
          cfg_presc_d = i_wdata[3:1];
          cfg_ramp_d  = i_wdata[4];
        end
        ADDR_DCYCLE: target_d = i_wdata;
        ADDR_STEP:   step_d   = i_wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cfg_on_q    <= 1'b0;
      cfg_presc_q <= 3'd0;
      cfg_ramp_q  <= 1'b0;
      target_q    <= 8'd0;
      step_q      <= 8'd0;
      pending_q   <= 1'b0;
      sticky_q    <= 1'b0;
      on_q        <= 1'b0;
      presc_q     <= 3'd0;
      duty_q      <= 8'd0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cfg_on_q    <= cfg_on_d;
      cfg_presc_q <= cfg_presc_d;
      cfg_ramp_q  <= cfg_ramp_d;
      target_q    <= target_d;
      step_q      <= step_d;
      pending_q   <= pending_d;
      sticky_q    <= sticky_d;
      on_q        <= on_d;
      presc_q     <= presc_d;
      duty_q      <= duty_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_rdata      = rdata_q;
  assign o_ack        = ack_q;
  assign o_on         = on_q;
  assign o_presc_mode = presc_q;
  assign o_duty_cycle = duty_q;
  assign o_busy       = busy;
  assign o_done       = done_q;

endmodule

// File: tb/tb_bam_cfg_ctrl.sv
// Bench for bam_cfg_ctrl: a flag-based behavioural model checked every cycle,
// plus directed sequences with hand-computed duty/status values.
module tb_bam_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'd0;
  logic       frame_end = 1'b0;

  logic [7:0] o_rdata;
  logic       o_ack;
  logic       o_on;
  logic [2:0] o_presc_mode;
  logic [7:0] o_duty_cycle;
  logic       o_busy;
  logic       o_done;

  int tests_run = 0;
  int tests_failed = 0;
  int done_seen = 0;
  bit check_en = 1'b0;

  bam_cfg_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_en      (wr_en),
    .i_rd_en      (rd_en),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_frame_end  (frame_end),
    .o_rdata      (o_rdata),
    .o_ack        (o_ack),
    .o_on         (o_on),
    .o_presc_mode (o_presc_mode),
    .o_duty_cycle (o_duty_cycle),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #10 clk = ~clk;

  bit         m_on, m_pend, m_ramping, m_done, m_sticky, m_ack;
  logic [2:0] m_presc;
  logic [7:0] m_rdata;
  int         m_duty;
  bit         s_on, s_ramp;
  logic [2:0] s_presc;
  int         s_target, s_step;

  task automatic model_step();
    bit wrote, was_on;
    int gap, mv;
    if (!rst_n) begin
      m_on = 0; m_pend = 0; m_ramping = 0; m_done = 0; m_sticky = 0; m_ack = 0;
      m_presc = 3'd0; m_rdata = 8'd0; m_duty = 0;
      s_on = 0; s_ramp = 0; s_presc = 3'd0; s_target = 0; s_step = 0;
      return;
    end
    wrote   = wr_en && (addr != 2'd3);
    m_ack   = wr_en || rd_en;
    m_rdata = 8'd0;
    m_done  = 0;
    if (rd_en && !wr_en) begin
      case (addr)
        2'd0:    m_rdata = {3'b000, s_ramp, s_presc, s_on};
        2'd1:    m_rdata = 8'(s_target);
        2'd2:    m_rdata = 8'(s_step);
        default: m_rdata = {5'b00000, m_sticky, m_pend, m_pend || m_ramping};
      endcase
      if (addr == 2'd3) m_sticky = 0;
    end
    if (wr_en && addr == 2'd0 && !wdata[0] && m_on) begin
      m_on = 0; m_duty = 0; m_presc = wdata[3:1]; m_pend = 0; m_ramping = 0;
    end else if (m_ramping) begin
      if (frame_end) begin
        m_on = s_on; m_presc = s_presc;
        gap = s_target - m_duty;
        if (!s_ramp || s_step == 0) m_duty = s_target;
        else begin
          mv = (gap < 0) ? -gap : gap;
          if (mv > s_step) mv = s_step;
          m_duty = m_duty + ((gap < 0) ? -mv : mv);
        end
        m_pend = wrote;
        if (m_duty == s_target) begin
          m_done = 1; m_sticky = 1; m_ramping = 0;
        end
      end else if (wrote) m_pend = 1;
    end else if (m_pend) begin
      if (frame_end || (!m_on && !wrote)) begin
        was_on = m_on;
        m_on = s_on; m_presc = s_presc; m_pend = wrote;
        if (s_on && s_ramp && s_step != 0 && (was_on ? m_duty : 0) != s_target) begin
          if (!was_on) m_duty = 0;
          m_ramping = 1;
        end else m_duty = s_target;
      end
    end else if (wrote) m_pend = 1;
    if (wr_en) begin
      case (addr)
        2'd0: begin s_on = wdata[0]; s_presc = wdata[3:1]; s_ramp = wdata[4]; end
        2'd1: s_target = int'(wdata);
        2'd2: s_step = int'(wdata);
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (check_en) begin
      tests_run++;
      if ({o_on, o_presc_mode, o_duty_cycle, o_busy, o_done, o_ack, o_rdata} !==
          {m_on, m_presc, 8'(m_duty), m_pend || m_ramping, m_done, m_ack, m_rdata}) begin
        tests_failed++;
        $display("[TB] FAIL model_cmp t=%0t actual on=%b presc=%0d duty=%h busy=%b done=%b ack=%b rdata=%h required on=%b presc=%0d duty=%h busy=%b done=%b ack=%b rdata=%h",
                 $time, o_on, o_presc_mode, o_duty_cycle, o_busy, o_done, o_ack, o_rdata,
                 m_on, m_presc, 8'(m_duty), m_pend || m_ramping, m_done, m_ack, m_rdata);
      end
      if (o_done === 1'b1) done_seen++;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    step_cycle();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    addr = a; rd_en = 1'b1;
    step_cycle();
    rd_en = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_end = 1'b1;
    step_cycle();
    frame_end = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; addr = 2'd0; wdata = 8'hFF; frame_end = 1'b1;
    idle(3);
    check_en = 1'b1;
    check_output("rst_outputs", {o_on, o_presc_mode, o_duty_cycle, o_busy, o_done, o_ack, o_rdata}, 0);
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; frame_end = 1'b0;
    bus_read(2'd3);
    check_output("rst_status", o_rdata, 8'h00);
    check_output("rst_status_ack", o_ack, 1);

    bus_write(2'd0, 8'h05);
    bus_write(2'd1, 8'h80);
    check_output("off_wait_on", o_on, 0);
    step_cycle();
    check_output("off_commit_on", o_on, 1);
    check_output("off_commit_presc", o_presc_mode, 2);
    check_output("off_commit_duty", o_duty_cycle, 8'h80);
    bus_write(2'd1, 8'h20);
    idle(3);
    check_output("pend_hold_duty", o_duty_cycle, 8'h80);
    check_output("pend_busy", o_busy, 1);
    pulse_frame();
    check_output("frame_commit_duty", o_duty_cycle, 8'h20);
    check_output("frame_commit_busy", o_busy, 0);

    bus_write(2'd1, 8'h00);
    pulse_frame();
    bus_write(2'd2, 8'h30);
    bus_write(2'd0, 8'h11);
    bus_write(2'd1, 8'h70);
    pulse_frame();
    check_output("ramp_entry_duty", o_duty_cycle, 8'h00);
    pulse_frame();
    check_output("ramp_up_1", o_duty_cycle, 8'h30);
    bus_read(2'd3);
    check_output("ramp_status", o_rdata, 8'h01);
    pulse_frame();
    check_output("ramp_up_2", o_duty_cycle, 8'h60);
    pulse_frame();
    check_output("ramp_up_sat", o_duty_cycle, 8'h70);
    check_output("ramp_up_done", o_done, 1);
    step_cycle();
    check_output("ramp_done_single", o_done, 0);
    bus_read(2'd3);
    check_output("sticky_read", o_rdata, 8'h04);
    bus_read(2'd3);
    check_output("sticky_cleared", o_rdata, 8'h00);

    bus_write(2'd2, 8'h00);
    bus_write(2'd1, 8'hFF);
    pulse_frame();
    check_output("jump_duty", o_duty_cycle, 8'hFF);
    bus_write(2'd2, 8'h80);
    bus_write(2'd1, 8'h01);
    pulse_frame();
    pulse_frame();
    check_output("ramp_dn_1", o_duty_cycle, 8'h7F);
    check_output("ramp_dn_1_done", o_done, 0);
    pulse_frame();
    check_output("ramp_dn_sat", o_duty_cycle, 8'h01);
    check_output("ramp_dn_done", o_done, 1);
    step_cycle();

    bus_write(2'd1, 8'hF0);
    pulse_frame();
    pulse_frame();
    check_output("abort_pre_duty", o_duty_cycle, 8'h81);
    bus_write(2'd0, 8'h00);
    check_output("safety_on", o_on, 0);
    check_output("safety_duty", o_duty_cycle, 8'h00);
    check_output("safety_busy", o_busy, 0);
    step_cycle();
    check_output("safety_no_done", o_done, 0);

    addr = 2'd2; wdata = 8'h00; wr_en = 1'b1; rd_en = 1'b1;
    step_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    check_output("wr_rd_ack", o_ack, 1);
    check_output("wr_rd_rdata", o_rdata, 8'h00);
    step_cycle();
    check_output("wr_rd_single_ack", o_ack, 0);
    bus_read(2'd2);
    check_output("wr_rd_written", o_rdata, 8'h00);
    bus_write(2'd0, 8'h01);
    step_cycle();
    check_output("reon_duty", o_duty_cycle, 8'hF0);
    bus_write(2'd1, 8'h40);
    addr = 2'd1; wdata = 8'h50; wr_en = 1'b1; frame_end = 1'b1;
    step_cycle();
    wr_en = 1'b0; frame_end = 1'b0;
    check_output("collide_old", o_duty_cycle, 8'h40);
    check_output("collide_busy", o_busy, 1);
    pulse_frame();
    check_output("collide_new", o_duty_cycle, 8'h50);

    bus_write(2'd0, 8'h00);
    bus_write(2'd2, 8'h40);
    bus_write(2'd0, 8'h11);
    step_cycle();
    check_output("turnon_ramp_on", o_on, 1);
    check_output("turnon_ramp_start", o_duty_cycle, 8'h00);
    pulse_frame();
    check_output("turnon_ramp_1", o_duty_cycle, 8'h40);
    pulse_frame();
    check_output("turnon_ramp_end", o_duty_cycle, 8'h50);
    step_cycle();

    bus_write(2'd1, 8'hC0);
    pulse_frame();
    pulse_frame();
    check_output("midramp_duty", o_duty_cycle, 8'h90);
    rst_n = 1'b0;
    step_cycle();
    check_output("midramp_reset", {o_on, o_duty_cycle, o_busy, o_done}, 0);
    rst_n = 1'b1;
    step_cycle();
    check_output("midramp_reset_done", o_done, 0);
    check_output("done_pulses", done_seen, 3);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
